// File: rtl/execute_stage_pipelined.sv
// Registered EX stage: single-cycle ALU ops (latency 1) and an iterative shift-add multiplier (latency DATA_W+1).
// A single-entry output register holds its result until out_ready; in_ready drops while it is full or while a multiply runs.
module execute_stage_pipelined #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_plus,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] branch_target,
  output logic              zero,
  output logic              overflow,
  output logic [REG_W-1:0]  dest_reg,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand, mplier, acc, acc_nxt;
  logic [DATA_W-1:0]   pend_bt;
  logic [REG_W-1:0]    pend_dest;

  logic [DATA_W-1:0]   op_b, neg_b, sum, diff, alu_res, bt_calc;
  logic [3:0]          func;
  logic                alu_ovf, is_mul, accept, mul_done;
  logic [REG_W-1:0]    dest_sel;

  assign op_b     = alu_src ? sign_ext_imm : read_data_2;
  assign func     = sign_ext_imm[3:0];
  assign neg_b    = ~op_b + DATA_W'(1);
  assign sum      = read_data_1 + op_b;
  assign diff     = read_data_1 + neg_b;
  assign bt_calc  = pc_plus + {sign_ext_imm[DATA_W-2:0], 1'b0};
  assign dest_sel = reg_dst ? rd : rt;
  assign is_mul   = (alu_op == 2'b10) && (func == 4'd6);

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign busy     = (state == S_MUL);
  assign accept   = in_valid && in_ready && !flush;
  assign mul_done = (state == S_MUL) && (cnt == CNT_W'(DATA_W - 1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (alu_op)
      2'b00: begin
        alu_res = sum;
        alu_ovf = (read_data_1[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != read_data_1[DATA_W-1]);
      end
      2'b01: begin
        alu_res = diff;
        alu_ovf = (read_data_1[DATA_W-1] == neg_b[DATA_W-1]) && (diff[DATA_W-1] != read_data_1[DATA_W-1]);
      end
      2'b11: alu_res = read_data_1 | op_b;
      default: begin
        case (func)
          4'd0: begin
            alu_res = sum;
            alu_ovf = (read_data_1[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != read_data_1[DATA_W-1]);
          end
          4'd1: begin
            alu_res = diff;
            alu_ovf = (read_data_1[DATA_W-1] == neg_b[DATA_W-1]) && (diff[DATA_W-1] != read_data_1[DATA_W-1]);
          end
          4'd2: alu_res = read_data_1 & op_b;
          4'd3: alu_res = read_data_1 | op_b;
          4'd4: alu_res = {{(DATA_W-1){1'b0}}, ($signed(read_data_1) < $signed(op_b))};
          4'd5: alu_res = ~(read_data_1 | op_b);
          4'd7: alu_res = read_data_1 >> 1;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      dest_reg      <= '0;
      cnt           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      pend_bt       <= '0;
      pend_dest     <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept && !is_mul) begin
        out_valid     <= 1'b1;
        alu_result    <= alu_res;
        branch_target <= bt_calc;
        zero          <= (alu_res == '0);
        overflow      <= alu_ovf;
        dest_reg      <= dest_sel;
      end else if (mul_done) begin
        out_valid     <= 1'b1;
        alu_result    <= acc_nxt;
        branch_target <= pend_bt;
        zero          <= (acc_nxt == '0);
        overflow      <= 1'b0;
        dest_reg      <= pend_dest;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Multiplier consumes one multiplier bit per cycle, LSB first.
      if (accept && is_mul) begin
        mcand     <= read_data_1;
        mplier    <= op_b;
        acc       <= '0;
        cnt       <= '0;
        pend_bt   <= bt_calc;
        pend_dest <= dest_sel;
      end else if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Directed plus randomized bench for execute_stage_pipelined against a transaction-level reference model.
module tb_execute_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        reg_dst, alu_src, zero, overflow, busy;
  logic [15:0] pc_plus, read_data_1, read_data_2, sign_ext_imm, alu_result, branch_target;
  logic [2:0]  rt, rd, dest_reg;
  logic [1:0]  alu_op;

  always #5 clk = ~clk;

  execute_stage_pipelined #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_plus(pc_plus), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .sign_ext_imm(sign_ext_imm), .rt(rt), .rd(rd), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .branch_target(branch_target), .zero(zero), .overflow(overflow), .dest_reg(dest_reg),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: output register contents plus cycles left on a running multiply.
  logic        m_ov;
  logic [15:0] m_res, m_bt;
  logic        m_ovf;
  logic [2:0]  m_dest;
  int          m_left;
  logic [15:0] p_res, p_bt;
  logic [2:0]  p_dest;

  function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b_reg,
                                  input logic [15:0] imm, input logic src, input logic [1:0] op,
                                  output logic [15:0] res, output logic ovf, output logic mul);
    logic [15:0] b, nb;
    longint      prod;
    int          code;
    b   = src ? imm : b_reg;
    nb  = 16'(-b);
    code = (op == 2'b00) ? 0 : (op == 2'b01) ? 1 : (op == 2'b11) ? 3 : int'(imm[3:0]);
    res = 16'h0;
    ovf = 1'b0;
    mul = (code == 6);
    case (code)
      0: begin res = 16'(a + b);  ovf = (a[15] == b[15])  && (res[15] != a[15]); end
      1: begin res = 16'(a + nb); ovf = (a[15] == nb[15]) && (res[15] != a[15]); end
      2: res = a & b;
      3: res = a | b;
      4: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      5: res = ~(a | b);
      6: begin prod = longint'(a) * longint'(b); res = prod[15:0]; end
      7: res = a >> 1;
      default: res = 16'h0;
    endcase
  endfunction

  task automatic cycle();
    logic        exp_rdy, acc_now, mm, v;
    logic [15:0] r, bt;
    logic [2:0]  dst;
    #1;
    exp_rdy = (m_left == 0) && (!m_ov || out_ready);
    if (!rst) begin
      chk("in_ready", in_ready, exp_rdy);
      chk("busy", busy, m_left != 0);
    end
    acc_now = in_valid && exp_rdy && !flush;
    ref_alu(read_data_1, read_data_2, sign_ext_imm, alu_src, alu_op, r, v, mm);
    bt  = 16'(pc_plus + 32'(sign_ext_imm) * 2);
    dst = reg_dst ? rd : rt;
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_left = 0; m_res = 0; m_bt = 0; m_ovf = 0; m_dest = 0;
    end else if (flush) begin
      m_ov = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ov = 1; m_res = p_res; m_bt = p_bt; m_ovf = 0; m_dest = p_dest;
      end else if (m_ov && out_ready) m_ov = 0;
    end else if (acc_now && mm) begin
      m_left = 16; p_res = r; p_bt = bt; p_dest = dst;
      if (m_ov && out_ready) m_ov = 0;
    end else if (acc_now) begin
      m_ov = 1; m_res = r; m_bt = bt; m_ovf = v; m_dest = dst;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("alu_result", alu_result, m_res);
      chk("branch_target", branch_target, m_bt);
      chk("zero", zero, m_res == 16'h0);
      chk("overflow", overflow, m_ovf);
      chk("dest_reg", dest_reg, m_dest);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic src, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] imm, input logic [15:0] pc);
    alu_op = op; alu_src = src; read_data_1 = a; read_data_2 = b; sign_ext_imm = imm; pc_plus = pc;
  endtask

  initial begin
    m_ov = 0; m_left = 0; m_res = 0; m_bt = 0; m_ovf = 0; m_dest = 0;
    p_res = 0; p_bt = 0; p_dest = 0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; reg_dst = 0; rt = 0; rd = 0;
    set_op(2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    cycle();
    rst = 0;
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_branch_target", branch_target, 0);
    chk("rst_flags", {zero, overflow}, 0);
    chk("rst_dest_reg", dest_reg, 0);

    // add immediate overflowing into the sign bit
    in_valid = 1; rt = 3; rd = 5; reg_dst = 0;
    set_op(2'b00, 1'b1, 16'h7FFF, 16'h0, 16'h0001, 16'h0);
    cycle();
    in_valid = 0;
    chk("add_result", alu_result, 16'h8000);
    chk("add_ovf", overflow, 1);
    chk("add_zero", zero, 0);
    chk("add_dest", dest_reg, 3);

    // beq-style subtract with a backward branch
    in_valid = 1;
    set_op(2'b01, 1'b0, 16'h1234, 16'h1234, 16'hFFFE, 16'h0010);
    cycle();
    in_valid = 0;
    chk("beq_zero", zero, 1);
    chk("beq_result", alu_result, 16'h0000);
    chk("beq_target", branch_target, 16'h000C);

    // multiply 3*5
    in_valid = 1; reg_dst = 1; rd = 6;
    set_op(2'b10, 1'b0, 16'h0003, 16'h0005, 16'h0006, 16'h0020);
    cycle();
    in_valid = 0;
    for (int i = 0; i < 15; i++) cycle();
    chk("mul_still_busy", busy, 1);
    chk("mul_not_ready", in_ready, 0);
    cycle();
    chk("mul_valid", out_valid, 1);
    chk("mul_result", alu_result, 16'h000F);
    chk("mul_dest", dest_reg, 6);

    // multiply whose product only has bits above the datapath
    in_valid = 1;
    set_op(2'b10, 1'b0, 16'h0100, 16'h0100, 16'h0006, 16'h0020);
    cycle();
    in_valid = 0;
    for (int i = 0; i < 16; i++) cycle();
    chk("mul2_result", alu_result, 16'h0000);
    chk("mul2_zero", zero, 1);

    // backpressure: first add held, second waits, then both move on release
    cycle();
    out_ready = 0; in_valid = 1;
    set_op(2'b00, 1'b0, 16'h0001, 16'h0002, 16'h0000, 16'h0);
    cycle();
    set_op(2'b00, 1'b0, 16'h0005, 16'h0006, 16'h0000, 16'h0);
    cycle();
    cycle();
    chk("bp_held", alu_result, 16'h0003);
    chk("bp_not_ready", in_ready, 0);
    out_ready = 1;
    cycle();
    in_valid = 0;
    chk("bp_valid", out_valid, 1);
    chk("bp_second", alu_result, 16'h000B);

    // flush on the fifth cycle of a multiply with a competing request
    cycle();
    in_valid = 1;
    set_op(2'b10, 1'b0, 16'h0007, 16'h0009, 16'h0006, 16'h0);
    cycle();
    set_op(2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h0);
    in_valid = 0;
    for (int i = 0; i < 4; i++) cycle();
    flush = 1; in_valid = 1;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_mul_valid", out_valid, 0);
    chk("flush_mul_busy", busy, 0);
    chk("flush_mul_ready", in_ready, 1);
    cycle();
    chk("flush_no_accept", out_valid, 0);

    // flush while a result is held
    out_ready = 0; in_valid = 1;
    cycle();
    in_valid = 0;
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_held_valid", out_valid, 0);
    out_ready = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      reg_dst   = 1'($urandom);
      rt        = 3'($urandom);
      rd        = 3'($urandom);
      set_op(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) read_data_1 = 16'h7FFF + 16'($urandom_range(0, 2));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage_pipelined.md
Name: execute_stage_pipelined

Overview:
Registered, parametrised execute stage for the 16-bit RISC pipeline, generalised in data and register-address width. It adds valid/ready handshakes on both sides, a single-entry EX/MEM output register, and an iterative shift-add multiplier that stalls upstream while it runs. It sits between the decode/register-read stage and the memory stage. It computes the ALU result, zero/overflow flags, branch target and destination register.

Parameters:
DATA_W, 16, datapath width (ALU operands, PC, immediate, result); legal values ≥ 4
REG_W, 3, register-address width for rt/rd/dest_reg

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous kill of in-flight and held results
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept an operation this cycle
pc_plus  in  DATA_W  PC+2 of the operation
read_data_1  in  DATA_W  operand A
read_data_2  in  DATA_W  operand B (register)
sign_ext_imm  in  DATA_W  sign-extended immediate; bits [3:0] are func
rt  in  REG_W  rt field
rd  in  REG_W  rd field
reg_dst  in  1  1: dest = rd, 0: dest = rt
alu_src  in  1  1: B = sign_ext_imm, 0: B = read_data_2
alu_op  in  2  00 add, 01 sub, 10 R-type by func, 11 or (immediate logic)
out_valid  out  1  registered result valid
out_ready  in  1  downstream accepts the result
alu_result  out  DATA_W  registered result
branch_target  out  DATA_W  registered pc_plus + (sign_ext_imm << 1)
zero  out  1  registered (alu_result == 0)
overflow  out  1  registered signed overflow (add/sub only, else 0)
dest_reg  out  REG_W  registered selected destination
busy  out  1  multiplier iterating

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, alu_result=0, branch_target=0, zero=0, overflow=0, dest_reg=0, busy=0, state=IDLE. Reset mid-multiply aborts it with no output.
- R-type func: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0), 5 nor, 6 mul (low DATA_W bits of the product), 7 srl by 1. Funcs 8–15 give result 0, overflow 0.
- Add/sub wrap modulo 2^DATA_W. Overflow = sign(A)==sign(B') && sign(res)!=sign(A), where B' = B for add and ~B+1 for sub.
- branch_target wraps modulo 2^DATA_W; the shift discards the immediate MSB.
- Fire condition: accept = in_valid && in_ready && !flush. All inputs are captured at accept; later input changes have no effect.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from out_ready and allows back-to-back throughput.
- State IDLE, non-mul accept: result registers load at the same edge; out_valid=1 the next cycle (latency 1).
- State IDLE, mul accept: go to MUL. busy=1, in_ready=0, iteration counter = 0, product accumulator = 0.
- State MUL: one multiplier bit is consumed per cycle, LSB first. After DATA_W iterations, the result registers load, out_valid=1 and state returns to IDLE. Accept-to-out_valid latency is DATA_W+1 cycles.
- MUL entry is accepted only when the output register is free, per in_ready. It completes regardless of out_ready.
- Output hold: while out_valid && !out_ready, all outputs stay stable.
- Handoff: out_valid && out_ready with no new result in the same cycle clears out_valid. A simultaneous new non-mul accept keeps out_valid=1 with the new data.
- flush (highest priority after rst): at the edge it clears out_valid, aborts MUL to IDLE, clears busy and blocks any accept that cycle. Data registers may keep stale values.
- dest_reg = reg_dst ? rd : rt, captured at accept.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, busy=0, all outputs 0.
- Add imm with alu_op=00, alu_src=1, A=0x7FFF, imm=0x0001, reg_dst=0, rt=3 → next cycle alu_result=0x8000, overflow=1, zero=0, dest_reg=3.
- Beq sub with alu_op=01, A=B=0x1234, pc_plus=0x0010, imm=0xFFFE → zero=1, alu_result=0, branch_target=0x000C.
- Mul with func=6, A=0x0003, B=0x0005 → busy/in_ready=0 for 16 cycles; out_valid on cycle 17 with alu_result=0x000F. Second mul with A=0x0100, B=0x0100 → alu_result=0x0000, zero=1.
- Backpressure: two back-to-back adds with out_ready=0 → first result held stable and in_ready=0. Raising out_ready → second accepted the same cycle; out_valid stays 1 and data updates.
- Flush on cycle 5 of a mul and flush while a result is held → out_valid=0, busy=0, in_ready=1 next cycle. A simultaneous in_valid is not accepted.
